vga_line_fetch_scheduler: RTL

- Schedules a single-port pixel memory between two requesters: display line prefetch (high priority) and host writes (low priority).
- Consumes the hPos/vPos counters from the 800x600@72Hz sync generator.
- During horizontal blanking, streams the next visible line from memory into the back bank of a ping-pong line buffer.
- Swaps banks at end of line.

---
 rtl/vga_line_fetch_scheduler_if.sv | 47 ++++
 rtl/vga_line_fetch_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_scheduler_if.sv
// Host, memory and line-buffer bus bundle for vga_line_fetch_scheduler.
// The master modport is the scheduler side; the slave modport is the
// surrounding host / memory / line-buffer side.
// Optional macro VGA_FETCH_HOST_READ_EN adds hostWeIn and hostRdDataOut.
interface vga_line_fetch_scheduler_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  hostReqIn;
  logic [ADDR_WIDTH-1:0] hostAddrIn;
  logic [DATA_WIDTH-1:0] hostDataIn;
  logic                  hostAckOut;
`ifdef VGA_FETCH_HOST_READ_EN
  logic                  hostWeIn;
  logic [DATA_WIDTH-1:0] hostRdDataOut;
`endif
  logic [ADDR_WIDTH-1:0] memAddrOut;
  logic [DATA_WIDTH-1:0] memWrDataOut;
  logic                  memRdEnOut;
  logic                  memWrEnOut;
  logic [DATA_WIDTH-1:0] memRdDataIn;
  logic                  lineWrEnOut;
  logic [7:0]            lineWrAddrOut;
  logic [DATA_WIDTH-1:0] lineWrDataOut;
  logic                  lineWrBankOut;
  logic                  lineBankOut;

  modport master (
    input  hostReqIn, hostAddrIn, hostDataIn, memRdDataIn,
`ifdef VGA_FETCH_HOST_READ_EN
    input  hostWeIn,
    output hostRdDataOut,
`endif
    output hostAckOut, memAddrOut, memWrDataOut, memRdEnOut, memWrEnOut,
    output lineWrEnOut, lineWrAddrOut, lineWrDataOut, lineWrBankOut, lineBankOut
  );

  modport slave (
    output hostReqIn, hostAddrIn, hostDataIn, memRdDataIn,
`ifdef VGA_FETCH_HOST_READ_EN
    output hostWeIn,
    input  hostRdDataOut,
`endif
    input  hostAckOut, memAddrOut, memWrDataOut, memRdEnOut, memWrEnOut,
    input  lineWrEnOut, lineWrAddrOut, lineWrDataOut, lineWrBankOut, lineBankOut
  );
endinterface

// File: rtl/vga_line_fetch_scheduler.sv
// Single-port pixel memory scheduler: display line prefetch into the back
// bank of a ping-pong line buffer (high priority) and host writes (low).
// A fetch is triggered at hPos == DISPLAY_WIDTH for the next visible line,
// streams WORDS_PER_LINE reads, and the banks swap at the last pixel of the
// line once the fetched line is ready.
// Optional macro VGA_FETCH_HOST_READ_EN: host reads (hostWeIn = 0) take two
// cycles in HOST and return data on hostRdDataOut together with hostAckOut.
module vga_line_fetch_scheduler #(
  parameter int DISPLAY_WIDTH  = 800,
  parameter int DISPLAY_HEIGHT = 600,
  parameter int H_TOTAL        = 1040,
  parameter int V_TOTAL        = 666,
  parameter int WORDS_PER_LINE = 100,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                        clkIn,
  input  logic                        rstIn,
  input  logic [15:0]                 hPosIn,
  input  logic [15:0]                 vPosIn,
  vga_line_fetch_scheduler_if.master  bus,
  output logic                        fetchUnderrunOut
);

  localparam logic [7:0]            LAST_WORD = 8'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(WORDS_PER_LINE);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOST
`ifdef VGA_FETCH_HOST_READ_EN
    , HOST_RD
`endif
  } state_t;

  state_t                state;
  state_t                stateNext;
  logic                  pending;
  logic                  ready;
  logic                  bank;
  logic                  underrun;
  logic [7:0]            wordCnt;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [ADDR_WIDTH-1:0] fetchBase;
  logic                  lineWrEnQ;
  logic [7:0]            lineWrAddrQ;

  logic                  trigger;
  logic                  targetZero;
  logic                  fetchBusy;
  logic                  triggerAccept;
  logic                  bankSwap;

  logic                  memRdEn;
  logic                  memWrEn;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWrData;
  logic                  hostAck;
`ifdef VGA_FETCH_HOST_READ_EN
  logic [DATA_WIDTH-1:0] hostRdData;
`endif

  // Decode the fetch trigger and decide whether it is accepted or an underrun
  always_comb begin
    targetZero    = (vPosIn == 16'(V_TOTAL - 1));
    trigger       = (hPosIn == 16'(DISPLAY_WIDTH)) &&
                    ((({1'b0, vPosIn} + 17'd1) < 17'(DISPLAY_HEIGHT)) || targetZero);
    fetchBusy     = (state == FETCH) || (state == DRAIN);
    triggerAccept = trigger && !fetchBusy && !pending;
    bankSwap      = (hPosIn == 16'(H_TOTAL - 1)) && ready;
  end

  // State register
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state and memory-port decode; a fresh trigger in IDLE beats the host
  always_comb begin
    stateNext = state;
    memRdEn   = 1'b0;
    memWrEn   = 1'b0;
    memAddr   = '0;
    memWrData = DATA_ZERO;
    hostAck   = 1'b0;
`ifdef VGA_FETCH_HOST_READ_EN
    hostRdData = DATA_ZERO;
`endif
    unique case (state)
      IDLE: begin
        if (pending || triggerAccept) stateNext = FETCH;
        else if (bus.hostReqIn)       stateNext = HOST;
      end
      FETCH: begin
        memRdEn = 1'b1;
        memAddr = fetchBase + ADDR_WIDTH'(wordCnt);
        if (wordCnt == LAST_WORD) stateNext = DRAIN;
      end
      DRAIN: begin
        stateNext = IDLE;
      end
      HOST: begin
        memAddr = bus.hostAddrIn;
`ifdef VGA_FETCH_HOST_READ_EN
        if (bus.hostWeIn) begin
          memWrEn   = 1'b1;
          memWrData = bus.hostDataIn;
          hostAck   = 1'b1;
          stateNext = IDLE;
        end else begin
          memRdEn   = 1'b1;
          stateNext = HOST_RD;
        end
`else
        memWrEn   = 1'b1;
        memWrData = bus.hostDataIn;
        hostAck   = 1'b1;
        stateNext = IDLE;
`endif
      end
`ifdef VGA_FETCH_HOST_READ_EN
      HOST_RD: begin
        hostAck    = 1'b1;
        hostRdData = bus.memRdDataIn;
        stateNext  = IDLE;
      end
`endif
      default: stateNext = IDLE;
    endcase
  end

  // Pending flag holds an accepted trigger until IDLE can start the fetch
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn)              pending <= 1'b0;
    else if (state == IDLE) pending <= 1'b0;
    else if (triggerAccept) pending <= 1'b1;
  end

  // Word counter restarts in IDLE and steps once per issued read
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn)               wordCnt <= '0;
    else if (state == IDLE)  wordCnt <= '0;
    else if (state == FETCH) wordCnt <= wordCnt + 8'd1;
  end

  // Line start addresses: next line is one line step on, line 0 restarts at 0
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      fetchBase <= '0;
      baseAddr  <= '0;
    end else begin
      if (triggerAccept) fetchBase <= targetZero ? '0 : baseAddr + LINE_STEP;
      if (state == DRAIN) baseAddr <= fetchBase;
    end
  end

  // Ready marks a completed line; the bank swap consumes it at end of line
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      ready <= 1'b0;
      bank  <= 1'b0;
    end else begin
      if (state == DRAIN) ready <= 1'b1;
      else if (bankSwap)  ready <= 1'b0;
      if (bankSwap) bank <= ~bank;
    end
  end

  // Sticky underrun: a trigger arrived while the previous one was still owed
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn)                             underrun <= 1'b0;
    else if (trigger && (fetchBusy || pending)) underrun <= 1'b1;
  end

  // Line-buffer write strobe and index trail each fetch read by one cycle
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      lineWrEnQ   <= 1'b0;
      lineWrAddrQ <= '0;
    end else begin
      lineWrEnQ   <= (state == FETCH);
      lineWrAddrQ <= (state == FETCH) ? wordCnt : 8'd0;
    end
  end

  assign bus.memRdEnOut    = memRdEn;
  assign bus.memWrEnOut    = memWrEn;
  assign bus.memAddrOut    = memAddr;
  assign bus.memWrDataOut  = memWrData;
  assign bus.hostAckOut    = hostAck;
`ifdef VGA_FETCH_HOST_READ_EN
  assign bus.hostRdDataOut = hostRdData;
`endif
  assign bus.lineWrEnOut   = lineWrEnQ;
  assign bus.lineWrAddrOut = lineWrAddrQ;
  assign bus.lineWrDataOut = lineWrEnQ ? bus.memRdDataIn : DATA_ZERO;
  assign bus.lineBankOut   = bank;
  assign bus.lineWrBankOut = ~bank;
  assign fetchUnderrunOut  = underrun;

endmodule
